// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   General-purpose register storage of 2**ADDR_WIDTH load-enabled registers.
//   It has one general write port and three combinational read ports (A, B, D).
//   A dedicated PC load/read path targets register PC_INDEX.
//   Writeback drives the write port and the PC update. Decode/operand fetch
//   consumes the read ports.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high; clears every register
//   write_enable   in   general write strobe
//   write_addr     in   general write destination
//   write_data     in   general write data
//   pc_load_enable in   PC write strobe (targets PC_INDEX)
//   pc_in          in   next PC value
//   read_addr_a/b/d in  read port selects
//   read_data_a/b/d out contents of the selected registers
//   pc_out         out  contents of register PC_INDEX
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, the read ports and pc_out forward the
//   value that will be written on the coming edge. General write data takes
//   priority over pc_in. Forwarding is forced to zero while reset is high.
//   When undefined, the outputs always show the stored contents.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_INDEX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  pc_load_enable,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic [ADDR_WIDTH-1:0] read_addr_d,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic [DATA_WIDTH-1:0] read_data_d,
  output logic [DATA_WIDTH-1:0] pc_out
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] view_s [NUM_REGS];
  logic [NUM_REGS-1:0]   load_en_s;

  // Write-address decoder: one-hot load enable, all zero when not writing
  always_comb begin
    load_en_s = '0;
    if (write_enable) begin
      load_en_s[write_addr] = 1'b1;
    end else begin
      load_en_s = '0;
    end
  end

  // Next-state per register; the general write beats the PC load on PC_INDEX
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (load_en_s[i]) begin
        regs_d[i] = write_data;
      end else if ((i == PC_INDEX) && pc_load_enable) begin
        regs_d[i] = pc_in;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarded view: regs_d already has the write-over-PC priority.
  // The view is forced to zero during reset so bypass data cannot leak out.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        view_s[i] = '0;
      end else begin
        view_s[i] = regs_d[i];
      end
    end
  end
`else
  // Stored view: outputs reflect register contents only
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view_s[i] = regs_q[i];
    end
  end
`endif

  // Every ADDR_WIDTH-bit address selects a real entry, so the muxes are fully decoded
  assign read_data_a = view_s[read_addr_a];
  assign read_data_b = view_s[read_addr_b];
  assign read_data_d = view_s[read_addr_d];
  assign pc_out      = view_s[PC_INDEX];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Purpose:
//   Directed bench for register_file. It covers:
//     - asynchronous reset
//     - basic write/read
//     - the PC load path
//     - write/PC conflict
//     - multi-port reads
//     - the same-cycle read of a register being written
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        pc_load_enable;
  logic [31:0] pc_in;
  logic [3:0]  read_addr_a;
  logic [3:0]  read_addr_b;
  logic [3:0]  read_addr_d;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic [31:0] read_data_d;
  logic [31:0] pc_out;

  int vectors;
  int miscompares;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .PC_INDEX(15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .write_enable   (write_enable),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .pc_load_enable (pc_load_enable),
    .pc_in          (pc_in),
    .read_addr_a    (read_addr_a),
    .read_addr_b    (read_addr_b),
    .read_addr_d    (read_addr_d),
    .read_data_a    (read_data_a),
    .read_data_b    (read_data_b),
    .read_data_d    (read_data_d),
    .pc_out         (pc_out)
  );

  // 10-unit clock period; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    write_enable = 1'b1;
    write_addr   = addr;
    write_data   = data;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    write_enable   = 1'b0;
    write_addr     = 4'd0;
    write_data     = 32'h0;
    pc_load_enable = 1'b0;
    pc_in          = 32'h0;
    read_addr_a    = 4'd0;
    read_addr_b    = 4'd0;
    read_addr_d    = 4'd0;

    // Power-on reset state
    #2;
    check("por_pc", pc_out, 32'h0);
    check("por_a", read_data_a, 32'h0);
    #1 reset = 1'b0;

    // Reset mid-cycle clears a written register immediately
    write_reg(4'd3, 32'hDEADBEEF);
    read_addr_a    = 4'd3;
    read_addr_b    = 4'd3;
    read_addr_d    = 4'd3;
    #1;
    check("r3_written", read_data_a, 32'hDEADBEEF);
    // A write pending alongside reset must not show or land
    write_enable   = 1'b1;
    write_addr     = 4'd3;
    write_data     = 32'h12345678;
    pc_load_enable = 1'b1;
    pc_in          = 32'h55555555;
    reset          = 1'b1;
    #1;
    check("rst_a", read_data_a, 32'h0);
    check("rst_b", read_data_b, 32'h0);
    check("rst_d", read_data_d, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    tick();
    check("rst_hold_a", read_data_a, 32'h0);
    check("rst_hold_pc", pc_out, 32'h0);
    write_enable   = 1'b0;
    pc_load_enable = 1'b0;
    #1 reset = 1'b0;
    tick();

    // Basic write/read
    write_reg(4'd5, 32'h0000000A);
    read_addr_a = 4'd5;
    read_addr_b = 4'd4;
    read_addr_d = 4'd6;
    #1;
    check("r5", read_data_a, 32'h0000000A);
    check("r4_clear", read_data_b, 32'h0);
    check("r6_clear", read_data_d, 32'h0);
    write_data = 32'h0000000B;
    tick();
    check("r5_hold", read_data_a, 32'h0000000A);

    // PC path
    read_addr_d    = 4'd15;
    pc_load_enable = 1'b1;
    pc_in          = 32'h4;
    tick();
    check("pc_4", pc_out, 32'h4);
    check("pc_4_d", read_data_d, 32'h4);
    pc_in = 32'h8;
    tick();
    check("pc_8", pc_out, 32'h8);
    pc_in = 32'hC;
    tick();
    check("pc_c", pc_out, 32'hC);
    check("pc_c_d", read_data_d, 32'hC);
    pc_load_enable = 1'b0;
    pc_in          = 32'h20;
    tick();
    check("pc_idle", pc_out, 32'hC);

    // Write conflict on the PC register: general write wins
    write_enable   = 1'b1;
    write_addr     = 4'd15;
    write_data     = 32'h00000100;
    pc_load_enable = 1'b1;
    pc_in          = 32'h00000010;
    tick();
    check("conf_pc", pc_out, 32'h00000100);
    write_addr = 4'd2;
    tick();
    write_enable   = 1'b0;
    pc_load_enable = 1'b0;
    read_addr_a    = 4'd2;
    #1;
    check("conf_r2", read_data_a, 32'h00000100);
    check("conf_pc2", pc_out, 32'h00000010);

    // Multi-port read
    write_reg(4'd1, 32'h11111111);
    write_reg(4'd7, 32'h77777777);
    write_reg(4'd9, 32'h99999999);
    read_addr_a = 4'd1;
    read_addr_b = 4'd7;
    read_addr_d = 4'd9;
    #1;
    check("mp_a", read_data_a, 32'h11111111);
    check("mp_b", read_data_b, 32'h77777777);
    check("mp_d", read_data_d, 32'h99999999);
    read_addr_a = 4'd7;
    read_addr_d = 4'd7;
    #1;
    check("same_a", read_data_a, 32'h77777777);
    check("same_b", read_data_b, 32'h77777777);
    check("same_d", read_data_d, 32'h77777777);
    check("r5_still", dut.view_s[5], 32'h0000000A);

    // Same-cycle read of a register being written
    write_reg(4'd8, 32'h00000001);
    write_enable = 1'b1;
    write_addr   = 4'd8;
    write_data   = 32'h000000C0;
    read_addr_a  = 4'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre", read_data_a, 32'h000000C0);
`else
    check("byp_pre", read_data_a, 32'h00000001);
`endif
    tick();
    write_enable = 1'b0;
    #1;
    check("byp_post", read_data_a, 32'h000000C0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
